// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-slot blanking and frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 1000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    fd_q, fd_d;
   logic                    load_frame;
   logic [3:0]              sel_digit;

   function automatic logic [6:0] decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = load ? digits_in : pend_dig_q;
      pend_dp_d  = load ? dp_in : pend_dp_q;
      fd_d       = 1'b0;
      load_frame = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_BLANK;
               cnt_d      = '0;
               idx_d      = '0;
               load_frame = 1'b1;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_BLANK_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
               if (cnt_q == CNT_SLOT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_d      = '0;
                     load_frame = 1'b1;
                     fd_d       = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end

      // A load on the boundary cycle bypasses pending so the newest data is shown.
      if (load_frame) begin
         act_dig_d = load ? digits_in : pend_dig_q;
         act_dp_d  = load ? dp_in : pend_dp_q;
      end
   end

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lead_blank;
   logic                  seen_nz;

   // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lead_blank = '0;
      seen_nz    = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (act_dig_d[4*i +: 4] != 4'd0) seen_nz = 1'b1;
         lead_blank[i] = !seen_nz;
      end
   end
`endif

   // Outputs are registered from next-state values so they change on the same edge as the state.
   always_comb begin
      sel_digit = act_dig_d[{idx_d, 2'b00} +: 4];
      seg_d     = 7'h00;
      dp_d      = 1'b0;
      an_d      = '0;
      if (state_d == ST_SHOW) begin
         an_d = NUM_DIGITS'(1) << idx_d;
         dp_d = act_dp_d[idx_d];
`ifdef SEG_SCAN_LZB_EN
         seg_d = lead_blank[idx_d] ? 7'h00 : decode(sel_digit);
`else
         seg_d = decode(sel_digit);
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         seg_q      <= '0;
         dp_q       <= 1'b0;
         an_q       <= '0;
         fd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         fd_q       <= fd_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random loads against a
// timeline model (slot = position / PRESCALE, blank while position mod PRESCALE < BLANK_CYC).
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 8;
   localparam int BC    = 2;
   localparam int FRAME = PS * ND;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic            load = 1'b0;
   logic [4*ND-1:0] digits_in = '0;
   logic [ND-1:0]   dp_in = '0;
   logic [6:0]      seg_out;
   logic            dp_out;
   logic [ND-1:0]   an_out;
   logic            frame_done;

   int errors = 0;
   int checks = 0;

   // Reference model: on/off flag, cycles elapsed since the scan started, frame data.
   bit              m_on = 1'b0;
   int              m_t = 0;
   logic [4*ND-1:0] m_pend = '0, m_act = '0;
   logic [ND-1:0]   m_pdp = '0, m_adp = '0;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
      .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_code(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
         4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
         4'd8: return 7'h7F;  4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [6:0]    e_seg = '0;
      logic [ND-1:0] e_an = '0;
      logic          e_dp = 1'b0;
      logic          e_fd = 1'b0;
      int            slot, phase;
      if (m_on) begin
         slot  = (m_t / PS) % ND;
         phase = m_t % PS;
         e_fd  = (m_t > 0) && (m_t % FRAME == 0);
         if (phase >= BC) begin
            e_an  = ND'(1) << slot;
            e_dp  = m_adp[slot];
            e_seg = seg_code(m_act[4*slot +: 4]);
`ifdef SEG_SCAN_LZB_EN
            if (slot > 0 && (m_act >> (4*slot)) == 0) e_seg = 7'h00;
`endif
         end
      end
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("an_out", 32'(an_out), 32'(e_an));
      check("dp_out", 32'(dp_out), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic model_reset();
      m_on = 1'b0; m_t = 0;
      m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
   endtask

   task automatic step();
      bit new_frame;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         new_frame = 1'b0;
         if (!en) m_on = 1'b0;
         else if (!m_on) begin m_on = 1'b1; m_t = 0; new_frame = 1'b1; end
         else begin m_t++; new_frame = (m_t % FRAME == 0); end
         if (new_frame) begin
            m_act = load ? digits_in : m_pend;
            m_adp = load ? dp_in : m_pdp;
         end
         if (load) begin m_pend = digits_in; m_pdp = dp_in; end
      end
      #1 compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p);
      digits_in = d; dp_in = p; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Advance until the scan sits in the SHOW part of the given slot; a miss counts as a failure.
   task automatic run_to_show(input int slot);
      int n = 0;
      while (!(m_on && ((m_t / PS) % ND) == slot && (m_t % PS) >= BC + 1) && n < 4*FRAME) begin
         step(); n++;
      end
      check("reach_show_slot", 32'(n < 4*FRAME), 32'd1);
   endtask

   initial begin
      // Reset held with enable and load active: everything stays dark.
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         digits_in = 16'($urandom); dp_in = 4'($urandom); load = i[0];
         step();
      end
      load = 1'b0; en = 1'b0;
      #3 rst_n = 1'b1;
      run(2);

      // Basic scan over two frames.
      pulse_load(16'h1234, 4'b0100);
      en = 1'b1;
      run(2*FRAME + 4);
      check("basic_show_an", 32'(an_out), 32'b0001);
      check("basic_show_seg", 32'(seg_out), 32'h66);

      // Mid-frame load during slot 1 is deferred to the next frame.
      run_to_show(1);
      pulse_load(16'h5678, 4'b0001);
      run(FRAME + 4);

      // Codes above 9 decode blank.
      pulse_load(16'hFA90, 4'b1010);
      run(2*FRAME);

      // Drop enable in slot 2, then restart from digit 0.
      run_to_show(2);
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(FRAME + 3);

      // Asynchronous reset mid-SHOW clears outputs before any clock edge.
      run_to_show(1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      run(2);
      #3 rst_n = 1'b1;
      run(3);

      // Leading zeros (blanked only when SEG_SCAN_LZB_EN is defined).
      pulse_load(16'h0050, 4'b0000);
      run(2*FRAME + 2);

      // Random loads, data and occasional enable drops.
      for (int i = 0; i < 400; i++) begin
         digits_in = 16'($urandom);
         dp_in     = 4'($urandom);
         load      = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         step();
      end
      load = 1'b0;

      // Load coincident with the frame wrap takes effect immediately.
      en = 1'b1;
      while (!(m_on && (m_t % FRAME) == FRAME - 1)) step();
      pulse_load(16'h9087, 4'b1111);
      run(FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-segment, multi-digit 7-segment display.
- Holds NUM_DIGITS packed 4-bit BCD digits and enables one digit anode at a time, rotating through the digits.
- Decodes the selected digit onto the shared segment bus.
- Inserts a blanking gap at each digit change to suppress ghosting.
- Applies newly loaded values only at frame boundaries, so no torn frame is ever displayed.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 is least significant; must be 2..8.
PRESCALE, 1000, clk cycles per digit slot; must be greater than BLANK_CYC.
BLANK_CYC, 16, cycles at the start of each slot with all anodes and segments off; must be 1 or more.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; low forces IDLE.
load  input  1  one-cycle strobe; captures digits_in and dp_in into the pending register.
digits_in  input  4*NUM_DIGITS  packed BCD; bits [4i+3:4i] hold digit i.
dp_in  input  NUM_DIGITS  decimal point per digit.
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-high.
dp_out  output  1  decimal point for the active digit, active-high.
an_out  output  NUM_DIGITS  one-hot digit enable, active-high.
frame_done  output  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Interface: single clock clk. rst_n is asynchronous, active-low.
- Reset: state=IDLE; slot counter=0; digit index=0; active and pending registers=0. seg_out, dp_out, an_out and frame_done are all 0 immediately on reset assertion.
- All outputs are registered. They are Moore functions of the state, digit index and active register.
- States:
  - IDLE: all outputs 0; counters held at 0.
  - BLANK: an_out=0, seg_out=0, dp_out=0; lasts BLANK_CYC cycles.
  - SHOW: an_out=one-hot(index); seg_out=decode(active digit[index]); dp_out=active dp[index]; lasts PRESCALE-BLANK_CYC cycles.
- Transitions:
  - IDLE→BLANK with index=0 when en=1. On this transition, active is loaded from pending.
  - BLANK→SHOW when the slot count reaches BLANK_CYC-1.
  - SHOW→BLANK when the slot count reaches PRESCALE-1. The counter resets and the index increments.
  - Wrap: index NUM_DIGITS-1 wraps to 0. On wrap, active is loaded from pending.
  - en=0 in any state → IDLE on the next edge; outputs go to 0 on that edge.
- Decode, 0..9 (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Codes 10..15 decode to 7'h00 (blank).
- load behaviour:
  - Writes pending on any cycle.
  - If load coincides with a wrap or an IDLE→BLANK transition, active takes digits_in/dp_in directly that cycle (the newest data wins).
  - Multiple loads within one frame: only the last is displayed.
- frame_done: asserted for exactly one cycle, coincident with the SHOW→BLANK edge of index NUM_DIGITS-1. Never asserted in IDLE.
- Slot counter width: $clog2(PRESCALE). No overflow is possible because the counter resets at PRESCALE-1.
- Reset mid-operation: immediate return to the reset values; pending contents are lost.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN, leading-zero blanking.
- When defined:
  - Digits above the most significant nonzero digit in active are displayed with seg_out=7'h00.
  - Digit 0 is never blanked.
  - an_out and dp_out are unaffected.
  - The blank mask is computed from active, so it updates only at frame boundaries.
- When undefined: all digits are decoded normally, leading zeros included.

Test Plan:
All scenarios use PRESCALE=8, BLANK_CYC=2, NUM_DIGITS=4.
1. Reset: hold rst_n=0 with en=1 and load pulsing → seg_out=0, an_out=0, dp_out=0, frame_done=0 throughout.
2. Basic scan: load 16'h1234, dp_in=4'b0100, then en=1 →
   - slot 0: 2 blank cycles, then 6 cycles of an_out=0001, seg_out=7'h66.
   - slot 1: an_out=0010, seg_out=7'h4F.
   - slot 2: an_out=0100, seg_out=7'h5B, dp_out=1.
   - slot 3: an_out=1000, seg_out=7'h06.
   - frame_done pulses once every 32 cycles.
3. Mid-frame load: during slot 1, load 16'h5678 → slots 1..3 still show 3, 2, 1; the next frame's slot 0 shows 7'h7F.
4. Invalid codes: load 16'hFA90 → digits 3 and 2 show 7'h00; digit 1 shows 7'h6F; digit 0 shows 7'h3F.
5. Enable/reset mid-SHOW:
   - Drop en in slot 2 → all outputs 0 the next cycle. Re-raise en → digit 0 BLANK, then SHOW.
   - Assert rst_n=0 mid-SHOW → outputs 0 without waiting for a clock edge.
6. With SEG_SCAN_LZB_EN defined: load 16'h0050 → digits 3 and 2 show seg_out=7'h00 with their anodes still cycling; digit 1 shows 7'h6D; digit 0 shows 7'h3F.
